axi_sram_slave: RTL and testbench

AXI4-subset responder backed by on-chip memory. It speaks the same reduced AXI4 channel set that `axi_self_test_master` drives and that `ddr_sdram_ctrl` accepts. It stands in for the DDR controller so the self-test master and other AXI masters can be run without DRAM timing, and it is the slave end of that interface. Bursts are INCR only, with one outstanding transaction and round-robin write/read arbitration.

---
 rtl/axi_sram_slave_if.sv | 37 +++
 rtl/axi_sram_slave.sv | 119 +++++++++++
 tb/tb_axi_sram_slave.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// Reduced AXI4 channel bundle shared by the self-test master, the DDR controller
// and the on-chip SRAM stand-in. Only INCR bursts, no IDs, OKAY-only responses.
interface axi_sram_slave_if #(
  parameter int A_WIDTH = 26,
  parameter int D_WIDTH = 16
);
  logic               awvalid;
  logic               awready;
  logic [A_WIDTH-1:0] awaddr;
  logic [7:0]         awlen;
  logic               wvalid;
  logic               wready;
  logic               wlast;
  logic [D_WIDTH-1:0] wdata;
  logic               bvalid;
  logic               bready;
  logic               arvalid;
  logic               arready;
  logic [A_WIDTH-1:0] araddr;
  logic [7:0]         arlen;
  logic               rvalid;
  logic               rready;
  logic               rlast;
  logic [D_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
           arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rlast, rdata
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
           arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rlast, rdata
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4-subset responder backed by an on-chip word array. One transaction in
// flight, round-robin between write and read at IDLE, addresses wrap modulo
// the memory depth. werr latches any wlast that disagrees with the burst length.
module axi_sram_slave #(
  parameter int A_WIDTH    = 26,
  parameter int D_WIDTH    = 16,
  parameter int D_LEVEL    = 1,
  parameter int MEM_AWIDTH = 10
) (
  input  logic               clk,
  input  logic               rstn,
  axi_sram_slave_if.slave    bus,
  output logic               werr
);
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t                  state;
  logic [D_WIDTH-1:0]      mem [1<<MEM_AWIDTH];
  logic [MEM_AWIDTH-1:0]   ptr;
  logic [7:0]              cnt;
  logic [8:0]              rem;
  logic                    last_was_read;
  logic                    aw_grant, ar_grant;
  logic                    wbeat, rload, rdone;
  logic                    wready_q, bvalid_q, rvalid_q, rlast_q;
  logic [D_WIDTH-1:0]      rdata_q;
  logic                    unused_addr_bits;

  // Grants are combinational so a waiting master is accepted in its first IDLE
  // cycle; gating with rstn keeps both readies low while reset is held.
  assign aw_grant = rstn & (state == IDLE) & bus.awvalid & (~bus.arvalid | last_was_read);
  assign ar_grant = rstn & (state == IDLE) & bus.arvalid & ~aw_grant;
  assign wbeat    = (state == WRITE) & bus.wvalid & wready_q;
  assign rload    = (state == READ) & (~rvalid_q | bus.rready) & (rem != 9'd0);
  assign rdone    = (state == READ) & rvalid_q & bus.rready & (rem == 9'd0);

  assign bus.awready = aw_grant;
  assign bus.arready = ar_grant;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rdata   = rdata_q;

  // Byte-offset bits and bits above the array range carry no meaning here.
  assign unused_addr_bits = ^{bus.awaddr, bus.araddr};

  // Array write port; contents are deliberately left out of reset.
  always_ff @(posedge clk)
    if (wbeat) mem[ptr] <= bus.wdata;

  // Transaction FSM: arbitration, burst counting, response and read pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      last_was_read <= 1'b1;
      ptr           <= '0;
      cnt           <= '0;
      rem           <= '0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      rdata_q       <= '0;
      werr          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_grant) begin
            ptr           <= bus.awaddr[D_LEVEL +: MEM_AWIDTH];
            cnt           <= bus.awlen;
            last_was_read <= 1'b0;
            wready_q      <= 1'b1;
            state         <= WRITE;
          end else if (ar_grant) begin
            ptr           <= bus.araddr[D_LEVEL +: MEM_AWIDTH];
            rem           <= {1'b0, bus.arlen} + 9'd1;
            last_was_read <= 1'b1;
            state         <= READ;
          end
        end
        WRITE: begin
          // Length alone ends the burst; wlast is only checked, never obeyed.
          if (wbeat) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 1'b1;
            if (bus.wlast != (cnt == 8'd0)) werr <= 1'b1;
            if (cnt == 8'd0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              state    <= WRESP;
            end
          end
        end
        WRESP: begin
          if (bus.bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        READ: begin
          // One-deep output register: refill whenever it is empty or draining.
          if (rload) begin
            rdata_q  <= mem[ptr];
            rvalid_q <= 1'b1;
            rlast_q  <= (rem == 9'd1);
            ptr      <= ptr + 1'b1;
            rem      <= rem - 9'd1;
          end else if (rdone) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: scenario tasks drive the bus as a master and compare
// against a word-array model updated from burst address/length arithmetic.
module tb_axi_sram_slave;
  localparam int AW    = 26;
  localparam int DW    = 16;
  localparam int DL    = 1;
  localparam int MW    = 10;
  localparam int DEPTH = 1 << MW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic werr;
  int   cyc    = 0;
  int   ntests = 0;
  int   nfail  = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic          werr_m;
  logic [DW-1:0] wbuf [256];
  logic          g_aw, g_ar;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_sram_slave_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  axi_sram_slave #(.A_WIDTH(AW), .D_WIDTH(DW), .D_LEVEL(DL), .MEM_AWIDTH(MW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .werr (werr)
  );

  // Full write burst as a master; bad_beat forces wlast on a non-final beat,
  // bstall holds bready low (with awvalid asserted), abort_after stops early.
  task automatic axi_write(input logic [AW-1:0] addr, input int len, input int bad_beat,
                           input int bstall, input int abort_after);
    int  k, t, nb, base;
    logic wl;
    base = int'(addr >> DL);
    bus.awaddr  = addr;
    bus.awlen   = len[7:0];
    bus.awvalid = 1'b1;
    @(negedge clk);
    g_aw = bus.awready;
    g_ar = bus.arready;
    t = 0;
    while (bus.awready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      ntests++; nfail++;
      $display("FAIL aw_timeout addr=%h awready never seen", addr);
      bus.awvalid = 1'b0;
      return;
    end
    k = cyc;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b1;
    nb = 0;
    while (nb <= len) begin
      wl = (nb == len) || (nb == bad_beat);
      bus.wdata = wbuf[nb];
      bus.wlast = wl;
      @(negedge clk);
      ntests++;
      if (bus.wready !== 1'b1 || bus.bvalid !== 1'b0) begin
        nfail++;
        $display("FAIL w_beat beat=%0d cyc=%0d (aw at %0d) got wready=%b bvalid=%b exp wready=1 bvalid=0",
                 nb, cyc, k, bus.wready, bus.bvalid);
      end
      mem_m[(base + nb) % DEPTH] = wbuf[nb];
      if (wl != (nb == len)) werr_m = 1'b1;
      @(posedge clk); #1;
      nb++;
      if (abort_after >= 0 && nb == abort_after) begin
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        return;
      end
    end
    bus.wvalid  = 1'b0;
    bus.wlast   = 1'b0;
    bus.awvalid = (bstall > 0);
    // Now in cycle k+len+2: the response must be up.
    @(negedge clk);
    for (int i = 0; i < bstall; i++) begin
      ntests++;
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
        nfail++;
        $display("FAIL b_stall cyc=%0d got bvalid=%b awready=%b exp bvalid=1 awready=0",
                 cyc, bus.bvalid, bus.awready);
      end
      @(negedge clk);
    end
    bus.awvalid = 1'b0;
    bus.bready  = 1'b1;
    ntests++;
    if (bus.bvalid !== 1'b1) begin
      nfail++;
      $display("FAIL b_valid cyc=%0d (aw at %0d, len %0d) got bvalid=%b exp 1", cyc, k, len, bus.bvalid);
    end
    @(posedge clk); #1;
    bus.bready = 1'b0;
    ntests++;
    if (bus.bvalid !== 1'b0 || werr !== werr_m) begin
      nfail++;
      $display("FAIL b_done got bvalid=%b werr=%b exp bvalid=0 werr=%b", bus.bvalid, werr, werr_m);
    end
  endtask

  // Read burst; mode 0 = rready always 1 (timing checked), 1 = toggling, 2 = random.
  task automatic axi_read(input logic [AW-1:0] addr, input int len, input int mode);
    int k, t, idx, base;
    logic stalled, prev_l;
    logic [DW-1:0] prev_d;
    base = int'(addr >> DL);
    bus.araddr  = addr;
    bus.arlen   = len[7:0];
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    @(negedge clk);
    g_aw = bus.awready;
    g_ar = bus.arready;
    t = 0;
    while (bus.arready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      ntests++; nfail++;
      $display("FAIL ar_timeout addr=%h arready never seen", addr);
      bus.arvalid = 1'b0;
      return;
    end
    k = cyc;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    idx = 0; stalled = 1'b0; prev_d = '0; prev_l = 1'b0; t = 0;
    while (idx <= len && t < 2000) begin
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = t[0];
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (stalled) begin
        ntests++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== prev_d || bus.rlast !== prev_l) begin
          nfail++;
          $display("FAIL r_hold beat=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   idx, bus.rvalid, bus.rdata, bus.rlast, prev_d, prev_l);
        end
      end
      if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
        ntests++;
        if (bus.rdata !== mem_m[(base + idx) % DEPTH] || bus.rlast !== (idx == len)) begin
          nfail++;
          $display("FAIL r_beat addr=%h beat=%0d got d=%h l=%b exp d=%h l=%b", addr, idx,
                   bus.rdata, bus.rlast, mem_m[(base + idx) % DEPTH], (idx == len));
        end
        if (mode == 0) begin
          ntests++;
          if (cyc != k + 2 + idx) begin
            nfail++;
            $display("FAIL r_timing beat=%0d got cycle %0d exp %0d", idx, cyc, k + 2 + idx);
          end
        end
        idx++;
      end
      stalled = bus.rvalid && !bus.rready;
      prev_d  = bus.rdata;
      prev_l  = bus.rlast;
      @(posedge clk); #1;
      t++;
    end
    bus.rready = 1'b0;
    ntests++;
    if (idx != len + 1 || bus.rvalid !== 1'b0) begin
      nfail++;
      $display("FAIL r_end addr=%h got beats=%0d rvalid=%b exp beats=%0d rvalid=0", addr, idx, bus.rvalid, len + 1);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.awvalid = 1'b1;
    bus.awaddr  = '0;
    bus.awlen   = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ntests++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.rdata, werr} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs got aw=%b ar=%b w=%b b=%b rv=%b rl=%b rd=%h werr=%b exp all 0",
               bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.rdata, werr);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    werr_m = 1'b0;
    @(negedge clk);
    ntests++;
    if (bus.awready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_release_awready got %b exp 1", bus.awready);
    end
    bus.awvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h1000 + 16'(i);
    axi_write(26'h10, 7, -1, 0, -1);
    ntests++;
    if (g_aw !== 1'b1) begin nfail++; $display("FAIL wr_grant got awready=%b exp 1", g_aw); end
    axi_read(26'h10, 7, 0);
    ntests++;
    if (werr !== 1'b0) begin nfail++; $display("FAIL wr_werr got %b exp 0", werr); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
    axi_write(26'h200, 7, -1, 5, -1);
    axi_read(26'h200, 7, 1);
  endtask

  task automatic test_arbitration();
    for (int i = 0; i < 2; i++) wbuf[i] = 16'($urandom);
    bus.araddr = 26'h10; bus.arlen = 8'd0; bus.arvalid = 1'b1;
    axi_write(26'h40, 1, -1, 0, -1);
    ntests++;
    if (g_aw !== 1'b1 || g_ar !== 1'b0) begin
      nfail++; $display("FAIL arb_first got aw=%b ar=%b exp aw=1 ar=0", g_aw, g_ar);
    end
    bus.awaddr = 26'h80; bus.awlen = 8'd0; bus.awvalid = 1'b1;
    axi_read(26'h40, 1, 0);
    ntests++;
    if (g_aw !== 1'b0 || g_ar !== 1'b1) begin
      nfail++; $display("FAIL arb_second got aw=%b ar=%b exp aw=0 ar=1", g_aw, g_ar);
    end
    wbuf[0] = 16'($urandom);
    bus.arvalid = 1'b1;
    axi_write(26'h80, 0, -1, 0, -1);
    bus.arvalid = 1'b0;
    ntests++;
    if (g_aw !== 1'b1 || g_ar !== 1'b0) begin
      nfail++; $display("FAIL arb_third got aw=%b ar=%b exp aw=1 ar=0", g_aw, g_ar);
    end
    axi_read(26'h80, 0, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
    axi_write(26'(1022 << DL), 3, -1, 0, -1);
    axi_read(26'h0, 1, 0);
    axi_read(26'(1022 << DL), 3, 0);
  endtask

  task automatic test_protocol_error();
    for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
    axi_write(26'h100, 3, 1, 0, -1);
    ntests++;
    if (werr !== 1'b1) begin nfail++; $display("FAIL perr_set got werr=%b exp 1", werr); end
    wbuf[0] = 16'($urandom);
    axi_write(26'h120, 0, -1, 0, -1);
    ntests++;
    if (werr !== 1'b1) begin nfail++; $display("FAIL perr_sticky got werr=%b exp 1", werr); end
    axi_read(26'h100, 3, 0);
    rstn = 1'b0;
    @(negedge clk);
    werr_m = 1'b0;
    ntests++;
    if (werr !== 1'b0) begin nfail++; $display("FAIL perr_reset got werr=%b exp 0", werr); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
    axi_write(26'h300, 7, -1, 0, 3);
    rstn = 1'b0;
    @(negedge clk);
    ntests++;
    if ({bus.wready, bus.bvalid, bus.awready, bus.arready} !== 4'b0) begin
      nfail++;
      $display("FAIL midrst_outputs got w=%b b=%b aw=%b ar=%b exp all 0",
               bus.wready, bus.bvalid, bus.awready, bus.arready);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    axi_read(26'h300, 2, 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int l;
    for (int n = 0; n < 8; n++) begin
      a = AW'($urandom);
      l = $urandom_range(0, 15);
      for (int i = 0; i <= l; i++) wbuf[i] = 16'($urandom);
      axi_write(a, l, -1, $urandom_range(0, 2), -1);
      axi_read(a, l, 2);
    end
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid  = 1'b0; bus.wlast  = 1'b0; bus.wdata = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0;
    bus.rready  = 1'b0;
    werr_m = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_arbitration();
    test_wrap();
    test_protocol_error();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
